// File: rtl/Falco_pkg.sv
// Falco_pkg
// Shared core-wide configuration constants.
//   INT_IQ_NUM : number of integer issue queue slots
package Falco_pkg;
    parameter int INT_IQ_NUM = 8;
endpackage : Falco_pkg

// File: rtl/int_iq_slot_allocator.sv
// int_iq_slot_allocator
// Tracks occupancy of the integer issue queue and hands out up to two free
// slots per cycle to the dispatch stage (older instruction first).
//
// Ports
//   clk                    : clock, all state updates on the rising edge
//   rst                    : synchronous active-high reset
//   dispatch_req0/1        : older / younger dispatch slot requests
//   recovery_flush         : squash all IQ entries
//   issue_slot_idx0/1      : slots leaving the IQ this cycle
//   issue_slot_idx0/1_valid: qualifiers for the issue indices
//   dispatch_slot_idx0/1   : lowest / second-lowest free slot
//   dispatch_instr0/1_valid: allocation grants (combinational)
//   entry_valid            : registered occupancy bitmap
//   free_count             : registered number of free slots
//   dispatch_stall         : fewer than two slots free
module int_iq_slot_allocator #(
    parameter int INT_IQ_NUM   = Falco_pkg::INT_IQ_NUM,
    parameter int INT_IQ_WIDTH = $clog2(INT_IQ_NUM)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dispatch_req0,
    input  logic                    dispatch_req1,
    input  logic                    recovery_flush,
    input  logic [INT_IQ_WIDTH-1:0] issue_slot_idx0,
    input  logic [INT_IQ_WIDTH-1:0] issue_slot_idx1,
    input  logic                    issue_slot_idx0_valid,
    input  logic                    issue_slot_idx1_valid,
    output logic [INT_IQ_WIDTH-1:0] dispatch_slot_idx0,
    output logic [INT_IQ_WIDTH-1:0] dispatch_slot_idx1,
    output logic                    dispatch_instr0_valid,
    output logic                    dispatch_instr1_valid,
    output logic [INT_IQ_NUM-1:0]   entry_valid,
    output logic                    dispatch_stall,
    output logic [INT_IQ_WIDTH:0]   free_count
);

    localparam logic [INT_IQ_WIDTH:0] FREE_ALL = (INT_IQ_WIDTH+1)'(INT_IQ_NUM);
    localparam logic [INT_IQ_WIDTH:0] FREE_ONE = (INT_IQ_WIDTH+1)'(1);
    localparam logic [INT_IQ_WIDTH:0] FREE_TWO = (INT_IQ_WIDTH+1)'(2);

    function automatic logic [INT_IQ_WIDTH:0] popcount(input logic [INT_IQ_NUM-1:0] v);
        logic [INT_IQ_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < INT_IQ_NUM; i++) begin
            c = c + {{INT_IQ_WIDTH{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [INT_IQ_NUM-1:0]   entry_valid_q, entry_valid_d;
    logic [INT_IQ_WIDTH:0]   free_count_q, free_count_d;
    logic [INT_IQ_WIDTH-1:0] idx0_s, idx1_s;
    logic                    found0_s, found1_s;
    logic                    grant0_s, grant1_s;
    logic [INT_IQ_NUM-1:0]   clr_mask_s, set_mask_s;
    logic [INT_IQ_WIDTH:0]   grant_cnt_s;

    // Lowest and second-lowest free slot, taken from the registered bitmap only
    // so slots freed by issue this cycle are not reused until the next one.
    always_comb begin
        idx0_s   = '0;
        idx1_s   = '0;
        found0_s = 1'b0;
        found1_s = 1'b0;
        for (int i = 0; i < INT_IQ_NUM; i++) begin
            if (!entry_valid_q[i] && !found0_s) begin
                idx0_s   = INT_IQ_WIDTH'(i);
                found0_s = 1'b1;
            end else if (!entry_valid_q[i] && !found1_s) begin
                idx1_s   = INT_IQ_WIDTH'(i);
                found1_s = 1'b1;
            end else begin
                idx0_s   = idx0_s;
                idx1_s   = idx1_s;
            end
        end
    end

    // Grants: the younger request is only served together with the older one;
    // reset and flush suppress both.
    always_comb begin
        grant0_s = dispatch_req0 && (free_count_q >= FREE_ONE) && !recovery_flush && !rst;
        grant1_s = dispatch_req1 && dispatch_req0 && (free_count_q >= FREE_TWO)
                   && !recovery_flush && !rst;
    end

    // Occupancy update. Issue clears are masked with the current bitmap so an
    // issue of an already-free slot (or a duplicate index) frees nothing extra.
    // Granted slots are free in the registered bitmap, so they never collide
    // with the clear mask.
    always_comb begin
        clr_mask_s = '0;
        set_mask_s = '0;
        for (int i = 0; i < INT_IQ_NUM; i++) begin
            clr_mask_s[i] = entry_valid_q[i] &&
                            ((issue_slot_idx0_valid && (issue_slot_idx0 == INT_IQ_WIDTH'(i))) ||
                             (issue_slot_idx1_valid && (issue_slot_idx1 == INT_IQ_WIDTH'(i))));
            set_mask_s[i] = (grant0_s && (idx0_s == INT_IQ_WIDTH'(i))) ||
                            (grant1_s && (idx1_s == INT_IQ_WIDTH'(i)));
        end
        grant_cnt_s = {{INT_IQ_WIDTH{1'b0}}, grant0_s} + {{INT_IQ_WIDTH{1'b0}}, grant1_s};
        if (recovery_flush) begin
            entry_valid_d = '0;
            free_count_d  = FREE_ALL;
        end else begin
            entry_valid_d = (entry_valid_q & ~clr_mask_s) | set_mask_s;
            free_count_d  = free_count_q + popcount(clr_mask_s) - grant_cnt_s;
        end
    end

    // State registers with synchronous reset overriding dispatch, issue and flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_valid_q <= '0;
            free_count_q  <= FREE_ALL;
        end else begin
            entry_valid_q <= entry_valid_d;
            free_count_q  <= free_count_d;
        end
    end

    assign dispatch_slot_idx0    = found0_s ? idx0_s : '0;
    assign dispatch_slot_idx1    = found1_s ? idx1_s : '0;
    assign dispatch_instr0_valid = grant0_s;
    assign dispatch_instr1_valid = grant1_s;
    assign entry_valid           = entry_valid_q;
    assign free_count            = free_count_q;
    assign dispatch_stall        = (free_count_q < FREE_TWO);

endmodule : int_iq_slot_allocator

// File: tb/tb_int_iq_slot_allocator.sv
// Self-checking bench for int_iq_slot_allocator: a table of directed vectors
// (combinational outputs checked in-cycle, post-edge state checked through a
// scoreboard queue) followed by a randomized invariant sequence.
module tb_int_iq_slot_allocator;

    logic       clk;
    logic       rst;
    logic       dispatch_req0, dispatch_req1, recovery_flush;
    logic [2:0] issue_slot_idx0, issue_slot_idx1;
    logic       issue_slot_idx0_valid, issue_slot_idx1_valid;
    logic [2:0] dispatch_slot_idx0, dispatch_slot_idx1;
    logic       dispatch_instr0_valid, dispatch_instr1_valid;
    logic [7:0] entry_valid;
    logic       dispatch_stall;
    logic [3:0] free_count;

    int tests_run = 0;
    int tests_failed = 0;

    int_iq_slot_allocator #(.INT_IQ_NUM(8), .INT_IQ_WIDTH(3)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .dispatch_req0         (dispatch_req0),
        .dispatch_req1         (dispatch_req1),
        .recovery_flush        (recovery_flush),
        .issue_slot_idx0       (issue_slot_idx0),
        .issue_slot_idx1       (issue_slot_idx1),
        .issue_slot_idx0_valid (issue_slot_idx0_valid),
        .issue_slot_idx1_valid (issue_slot_idx1_valid),
        .dispatch_slot_idx0    (dispatch_slot_idx0),
        .dispatch_slot_idx1    (dispatch_slot_idx1),
        .dispatch_instr0_valid (dispatch_instr0_valid),
        .dispatch_instr1_valid (dispatch_instr1_valid),
        .entry_valid           (entry_valid),
        .dispatch_stall        (dispatch_stall),
        .free_count            (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector: ctl = {rst, req0, req1, flush}; is0/is1 = {valid, idx[2:0]}
    typedef struct {
        logic [3:0] ctl;
        logic [3:0] is0;
        logic [3:0] is1;
        logic       chk;
        logic [1:0] g;
        logic [2:0] x0;
        logic [2:0] x1;
        logic       st;
        logic [7:0] ev;
        logic [3:0] fc;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] ev;
        logic [3:0] fc;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    task automatic add(input logic [3:0] ctl, input logic [3:0] is0, input logic [3:0] is1,
                       input logic chk, input logic [1:0] g, input logic [2:0] x0,
                       input logic [2:0] x1, input logic st, input logic [7:0] ev,
                       input logic [3:0] fc);
        vec_t v;
        v.ctl = ctl; v.is0 = is0; v.is1 = is1; v.chk = chk; v.g = g;
        v.x0 = x0; v.x1 = x1; v.st = st; v.ev = ev; v.fc = fc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int id, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, id, act, exp);
        end
    endtask

    function automatic int zeros(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) if (v[i] == 1'b0) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        logic [7:0] ev_before;

        rst = 1'b1; dispatch_req0 = 1'b0; dispatch_req1 = 1'b0; recovery_flush = 1'b0;
        issue_slot_idx0 = 3'd0; issue_slot_idx1 = 3'd0;
        issue_slot_idx0_valid = 1'b0; issue_slot_idx1_valid = 1'b0;

        //   ctl      is0      is1      chk   g      x0    x1    st    ev      fc
        add(4'b1000, 4'h0,    4'h0,    1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 8'h00, 4'd8); // reset
        add(4'b1110, 4'h0,    4'h0,    1'b1, 2'b00, 3'd0, 3'd1, 1'b0, 8'h00, 4'd8); // reqs under rst
        add(4'b0110, 4'h0,    4'h0,    1'b1, 2'b11, 3'd0, 3'd1, 1'b0, 8'h03, 4'd6); // fill
        add(4'b0110, 4'h0,    4'h0,    1'b1, 2'b11, 3'd2, 3'd3, 1'b0, 8'h0F, 4'd4);
        add(4'b0110, 4'h0,    4'h0,    1'b1, 2'b11, 3'd4, 3'd5, 1'b0, 8'h3F, 4'd2);
        add(4'b0110, 4'h0,    4'h0,    1'b1, 2'b11, 3'd6, 3'd7, 1'b0, 8'hFF, 4'd0);
        add(4'b0100, 4'b1101, 4'h0,    1'b1, 2'b00, 3'd0, 3'd0, 1'b1, 8'hDF, 4'd1); // full, issue 5
        add(4'b0100, 4'h0,    4'h0,    1'b1, 2'b10, 3'd5, 3'd0, 1'b1, 8'hFF, 4'd0); // reuse 5
        add(4'b0000, 4'b1011, 4'b1011, 1'b1, 2'b00, 3'd0, 3'd0, 1'b1, 8'hF7, 4'd1); // dup issue 3
        add(4'b0000, 4'b1011, 4'b1011, 1'b1, 2'b00, 3'd3, 3'd0, 1'b1, 8'hF7, 4'd1); // already free
        add(4'b0100, 4'b1000, 4'h0,    1'b1, 2'b10, 3'd3, 3'd0, 1'b1, 8'hFE, 4'd1); // grant 3, free 0
        add(4'b0110, 4'h0,    4'h0,    1'b1, 2'b10, 3'd0, 3'd0, 1'b1, 8'hFF, 4'd0); // one free
        add(4'b0101, 4'h0,    4'h0,    1'b1, 2'b00, 3'd0, 3'd0, 1'b1, 8'h00, 4'd8); // flush
        add(4'b0010, 4'h0,    4'h0,    1'b1, 2'b00, 3'd0, 3'd1, 1'b0, 8'h00, 4'd8); // req1 only
        add(4'b0110, 4'h0,    4'h0,    1'b1, 2'b11, 3'd0, 3'd1, 1'b0, 8'h03, 4'd6);
        add(4'b0110, 4'h0,    4'h0,    1'b1, 2'b11, 3'd2, 3'd3, 1'b0, 8'h0F, 4'd4);
        add(4'b0101, 4'b1010, 4'h0,    1'b1, 2'b00, 3'd4, 3'd5, 1'b0, 8'h00, 4'd8); // flush+issue
        add(4'b0100, 4'h0,    4'b1110, 1'b1, 2'b10, 3'd0, 3'd1, 1'b0, 8'h01, 4'd7); // issue free 6
        add(4'b0110, 4'b1000, 4'h0,    1'b1, 2'b11, 3'd1, 3'd2, 1'b0, 8'h06, 4'd6); // issue+grant
        add(4'b1110, 4'b1001, 4'h0,    1'b1, 2'b00, 3'd0, 3'd3, 1'b0, 8'h00, 4'd8); // mid-op rst
        add(4'b0100, 4'h0,    4'h0,    1'b1, 2'b10, 3'd0, 3'd1, 1'b0, 8'h01, 4'd7);

        foreach (vecs[k]) begin
            @(negedge clk);
            {rst, dispatch_req0, dispatch_req1, recovery_flush} = vecs[k].ctl;
            {issue_slot_idx0_valid, issue_slot_idx0} = vecs[k].is0;
            {issue_slot_idx1_valid, issue_slot_idx1} = vecs[k].is1;
            #1;
            if (vecs[k].chk) begin
                check("grant0", k, int'(dispatch_instr0_valid), int'(vecs[k].g[1]));
                check("grant1", k, int'(dispatch_instr1_valid), int'(vecs[k].g[0]));
                check("idx0",   k, int'(dispatch_slot_idx0),    int'(vecs[k].x0));
                check("idx1",   k, int'(dispatch_slot_idx1),    int'(vecs[k].x1));
                check("stall",  k, int'(dispatch_stall),        int'(vecs[k].st));
            end
            e.id = k; e.ev = vecs[k].ev; e.fc = vecs[k].fc;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", k, 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("entry_valid", e.id, int'(entry_valid), int'(e.ev));
                check("free_count",  e.id, int'(free_count),  int'(e.fc));
            end
        end

        // Randomized sequence: legality of grants and the free-count invariant.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rst = 1'b0;
            dispatch_req0 = 1'($urandom_range(0, 1));
            dispatch_req1 = 1'($urandom_range(0, 1));
            recovery_flush = ($urandom_range(0, 19) == 0);
            issue_slot_idx0_valid = 1'($urandom_range(0, 1));
            issue_slot_idx1_valid = 1'($urandom_range(0, 1));
            issue_slot_idx0 = 3'($urandom_range(0, 7));
            issue_slot_idx1 = 3'($urandom_range(0, 7));
            #1;
            ev_before = entry_valid;
            check("rnd_stall", 1000 + n, int'(dispatch_stall), int'(zeros(ev_before) < 2));
            if (dispatch_instr1_valid)
                check("rnd_g1_needs_g0", 1000 + n, int'(dispatch_instr0_valid), 1);
            if (dispatch_instr0_valid)
                check("rnd_slot0_free", 1000 + n, int'(ev_before[dispatch_slot_idx0]), 0);
            if (dispatch_instr1_valid)
                check("rnd_slot1_free", 1000 + n,
                      int'(ev_before[dispatch_slot_idx1] || dispatch_slot_idx1 <= dispatch_slot_idx0), 0);
            @(posedge clk);
            #1;
            check("rnd_free_invariant", 1000 + n, int'(free_count), zeros(entry_valid));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_int_iq_slot_allocator

// File: doc/int_iq_slot_allocator.md
INT_IQ_SLOT_ALLOCATOR -- requirements
Module: int_iq_slot_allocator

Interface
REQ-001 SHALL have parameter INT_IQ_NUM, default Falco_pkg::INT_IQ_NUM (8), meaning the number of integer issue queue slots.
REQ-002 SHALL have parameter INT_IQ_WIDTH, default $clog2(INT_IQ_NUM) (3), meaning the slot index width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 dispatch_req0  input  1  older dispatch instruction requests a slot.
REQ-006 dispatch_req1  input  1  younger dispatch instruction requests a slot.
REQ-007 recovery_flush  input  1  mispredict recovery; squash all IQ entries.
REQ-008 issue_slot_idx0 / issue_slot_idx1  input  INT_IQ_WIDTH each  slots leaving the IQ this cycle.
REQ-009 issue_slot_idx0_valid / issue_slot_idx1_valid  input  1 each  qualify the issue indices.
REQ-010 dispatch_slot_idx0 / dispatch_slot_idx1  output  INT_IQ_WIDTH each  allocated slot indices.
REQ-011 dispatch_instr0_valid / dispatch_instr1_valid  output  1 each  allocation grants.
REQ-012 entry_valid  output  logic [INT_IQ_NUM]  registered occupancy bitmap.
REQ-013 free_count  output  INT_IQ_WIDTH+1  registered number of free slots.
REQ-014 dispatch_stall  output  1  fewer than 2 slots free (free_count < 2).

Function
REQ-015 SHALL select dispatch_slot_idx0 as the lowest-numbered slot with entry_valid==0, and dispatch_slot_idx1 as the second-lowest; both come from the registered bitmap only.
REQ-016 SHALL not reuse slots freed by issue in the same cycle; they become allocatable in the next cycle.
REQ-017 SHALL set grant0 = dispatch_req0 && free_count>=1 && ~recovery_flush.
REQ-018 SHALL set grant1 = dispatch_req1 && dispatch_req0 && free_count>=2 && ~recovery_flush; a younger request is never granted without the older one.
REQ-019 SHALL drive both grants combinationally in the cycle of the request; the slot shows entry_valid==1 one cycle later.
REQ-020 SHALL, on a clock edge with a grant, set entry_valid for each granted slot; on a valid issue index, clear entry_valid of that slot.
REQ-021 SHALL ignore an issue index whose slot is already free, with no change to free_count.
REQ-022 SHALL clear a slot once when issue_slot_idx0==issue_slot_idx1 with both valid; free_count increments by 1.
REQ-023 SHALL update free_count each edge as free_count + (slots actually cleared) - (grants), so that free_count always equals the number of zero bits in entry_valid.
REQ-024 SHALL, when recovery_flush=1, clear all entry_valid bits and set free_count=INT_IQ_NUM at the next edge; flush overrides same-cycle issue frees.
REQ-025 SHALL drive the index outputs to 0 when the corresponding slot does not exist (free_count<1 for idx0, <2 for idx1); the index value is don't-care whenever its grant is 0.
REQ-026 SHALL compute dispatch_stall combinationally from the registered free_count.

Reset
REQ-027 SHALL, while rst=1, clear entry_valid to all 0 and set free_count=INT_IQ_NUM at the next edge; grants are forced to 0 during rst.
REQ-028 SHALL, when rst is asserted mid-operation, override dispatch, issue and flush in that cycle.
REQ-029 SHALL drive dispatch_stall=0 and dispatch_slot_idx0=0, dispatch_slot_idx1=1 in the first cycle after reset.

Verification
REQ-030 Reset, then req0=req1=1 for 4 cycles -> grants (0,1),(2,3),(4,5),(6,7); free_count 8,6,4,2,0; stall=1 after the 4th edge.
REQ-031 Full IQ, issue_slot_idx0=5 valid with req0=1 in the same cycle -> grant0=0 that cycle; next cycle grant0=1, idx0=5, free_count returns to 0 after the edge.
REQ-032 entry_valid=8'b1111_1110, req0=req1=1 -> grant0=1 at idx0=0, grant1=0; stall=1; free_count becomes 0.
REQ-033 req1=1, req0=0 with 8 free -> no grants; entry_valid unchanged.
REQ-034 Half full (slots 0-3), recovery_flush=1 with req0=1 and issue idx 2 valid -> no grants; next cycle entry_valid=0, free_count=8.
REQ-035 Slot 3 occupied, issue idx0=idx1=3 both valid -> slot 3 freed once, free_count +1; a repeated issue of 3 the next cycle produces no change.
